// File: rtl/cpu_multicycle_control.sv
// ---------------------------------------------------------------------------
// cpu_multicycle_control
// Multi-cycle LEGv8 control unit. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake with a stall
// timeout, resolves CBZ/B branches, and parks in sticky HALTED/ERROR states.
// It also counts retired instructions, saturating at all-ones.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   inst31_21                     opcode field, sampled in FETCH when mem_ready=1
//   zero                          ALU zero flag, used by CBZ in EXEC
//   mem_ready                     memory access completes this cycle
//   Reg2Loc .. PCWrite            datapath mux selects and write strobes
//   halted, err                   sticky status flags
//   state                         current state encoding (debug)
//   retire_cnt                    saturating retired-instruction count
// ---------------------------------------------------------------------------
module cpu_multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int RETIRE_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [10:0]         inst31_21,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                Reg2Loc,
   output logic                Branch,
   output logic                MemRead,
   output logic                MemtoReg,
   output logic [1:0]          ALUOp,
   output logic                MemWrite,
   output logic                ALUSrc,
   output logic                RegWrite,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                halted,
   output logic                err,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] retire_cnt
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_ILL   = 3'd0,
      C_LDUR  = 3'd1,
      C_STUR  = 3'd2,
      C_RTYPE = 3'd3,
      C_CBZ   = 3'd4,
      C_B     = 3'd5,
      C_HALT  = 3'd6
   } cls_t;

   // Instruction class of an 11-bit opcode; anything unlisted is illegal.
   function automatic cls_t classify(input logic [10:0] op);
      cls_t c;
      casez (op)
         11'b11111000010: c = C_LDUR;
         11'b11111000000: c = C_STUR;
         11'b10001011000: c = C_RTYPE;   // ADD
         11'b11001011000: c = C_RTYPE;   // SUB
         11'b10001010000: c = C_RTYPE;   // AND
         11'b10101010000: c = C_RTYPE;   // ORR
         11'b10110100???: c = C_CBZ;
         11'b000101?????: c = C_B;
         11'b11111111111: c = C_HALT;
         default:         c = C_ILL;
      endcase
      return c;
   endfunction

   state_t                state_r;
   state_t                state_s;
   logic [10:0]           opcode_r;
   logic [TO_W-1:0]       to_cnt_r;
   logic [RETIRE_W-1:0]   retire_r;
   cls_t                  cls_s;
   logic                  to_hit_s;
   logic                  retire_s;
   logic                  waiting_s;

   assign cls_s     = classify(opcode_r);
   assign to_hit_s  = (to_cnt_r == TO_W'(MEM_TIMEOUT));
   assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;

   // Next-state selection.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: state_s = S_FETCH;
         S_FETCH: begin
            if (mem_ready)     state_s = S_DECODE;
            else if (to_hit_s) state_s = S_ERROR;
            else               state_s = S_FETCH;
         end
         S_DECODE: begin
            if (cls_s == C_HALT)     state_s = S_HALTED;
            else if (cls_s == C_ILL) state_s = S_ERROR;
            else                     state_s = S_EXEC;
         end
         S_EXEC: begin
            case (cls_s)
               C_RTYPE:      state_s = S_WB;
               C_LDUR:       state_s = S_MEM;
               C_STUR:       state_s = S_MEM;
               C_CBZ:        state_s = S_FETCH;
               C_B:          state_s = S_FETCH;
               default:      state_s = S_ERROR;
            endcase
         end
         S_MEM: begin
            if (mem_ready)     state_s = (cls_s == C_LDUR) ? S_WB : S_FETCH;
            else if (to_hit_s) state_s = S_ERROR;
            else               state_s = S_MEM;
         end
         S_WB:     state_s = S_FETCH;
         S_HALTED: state_s = S_HALTED;
         S_ERROR:  state_s = S_ERROR;
         default:  state_s = S_ERROR;
      endcase
   end

   // An instruction retires when control returns to FETCH after EXEC/MEM/WB,
   // and HALT retires on its way into HALTED.
   always_comb begin
      if ((state_s == S_FETCH) &&
          ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB))) begin
         retire_s = 1'b1;
      end else if ((state_s == S_HALTED) && (state_r == S_DECODE)) begin
         retire_s = 1'b1;
      end else begin
         retire_s = 1'b0;
      end
   end

   // State, latched opcode, stall counter and retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         opcode_r <= 11'd0;
         to_cnt_r <= '0;
         retire_r <= '0;
      end else begin
         state_r <= state_s;
         if ((state_r == S_FETCH) && mem_ready) begin
            opcode_r <= inst31_21;
         end
         // Counts consecutive stalled cycles; any state change restarts it.
         if (waiting_s && (state_s == state_r)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= '0;
         end
         if (retire_s && (retire_r != {RETIRE_W{1'b1}})) begin
            retire_r <= retire_r + RETIRE_W'(1);
         end
      end
   end

   // Control outputs from current state and latched opcode; IRWrite/PCWrite in
   // FETCH follow mem_ready and PCWrite in EXEC follows zero for CBZ, since
   // those strobes must land in the same cycle as the event they qualify.
   always_comb begin
      Reg2Loc  = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemtoReg = 1'b0;
      ALUOp    = 2'b00;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      case (state_r)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            Reg2Loc = (cls_s == C_STUR) || (cls_s == C_CBZ);
         end
         S_EXEC: begin
            case (cls_s)
               C_RTYPE: ALUOp = 2'b10;
               C_LDUR:  ALUSrc = 1'b1;
               C_STUR:  ALUSrc = 1'b1;
               C_CBZ: begin
                  Reg2Loc = 1'b1;
                  ALUOp   = 2'b01;
                  Branch  = 1'b1;
                  PCWrite = zero;
               end
               C_B: begin
                  Branch  = 1'b1;
                  PCWrite = 1'b1;
               end
               default: ALUOp = 2'b00;
            endcase
         end
         S_MEM: begin
            if (cls_s == C_LDUR) begin
               MemRead = 1'b1;
               ALUSrc  = 1'b1;
            end else begin
               MemWrite = 1'b1;
               Reg2Loc  = 1'b1;
               ALUSrc   = 1'b1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cls_s == C_LDUR);
         end
         S_HALTED: halted = 1'b1;
         S_ERROR:  err    = 1'b1;
         default:  err    = 1'b0;
      endcase
   end

   assign state      = state_r;
   assign retire_cnt = retire_r;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
module tb_cpu_multicycle_control;

   localparam int RW_W = 3;  // narrow retire counter so saturation is reachable

   // Output word layout: {halted, err, Reg2Loc, Branch, MemRead, MemtoReg,
   //                      ALUOp[1:0], MemWrite, ALUSrc, RegWrite, IRWrite, PCWrite}
   localparam logic [12:0] O_NONE = 13'h0000;
   localparam logic [12:0] O_HLT  = 13'h1000;
   localparam logic [12:0] O_ERR  = 13'h0800;
   localparam logic [12:0] R2L    = 13'h0400;
   localparam logic [12:0] BR     = 13'h0200;
   localparam logic [12:0] MR     = 13'h0100;
   localparam logic [12:0] M2R    = 13'h0080;
   localparam logic [12:0] AOP10  = 13'h0040;
   localparam logic [12:0] AOP01  = 13'h0020;
   localparam logic [12:0] MW     = 13'h0010;
   localparam logic [12:0] AS     = 13'h0008;
   localparam logic [12:0] RW     = 13'h0004;
   localparam logic [12:0] IRW    = 13'h0002;
   localparam logic [12:0] PCW    = 13'h0001;
   localparam logic [12:0] F_DONE = 13'h0103;  // MemRead|IRWrite|PCWrite

   logic            clk;
   logic            rst_n;
   logic [10:0]     inst31_21;
   logic            zero;
   logic            mem_ready;
   logic            Reg2Loc, Branch, MemRead, MemtoReg, MemWrite, ALUSrc;
   logic            RegWrite, IRWrite, PCWrite, halted, err;
   logic [1:0]      ALUOp;
   logic [2:0]      state;
   logic [RW_W-1:0] retire_cnt;
   logic [12:0]     out_w;

   assign out_w = {halted, err, Reg2Loc, Branch, MemRead, MemtoReg, ALUOp,
                   MemWrite, ALUSrc, RegWrite, IRWrite, PCWrite};

   cpu_multicycle_control #(.MEM_TIMEOUT(15), .RETIRE_W(RW_W)) dut (
      .clk(clk), .rst_n(rst_n), .inst31_21(inst31_21), .zero(zero),
      .mem_ready(mem_ready), .Reg2Loc(Reg2Loc), .Branch(Branch),
      .MemRead(MemRead), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .halted(halted), .err(err),
      .state(state), .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  st;
      logic [12:0] out;
   } exp_t;

   typedef struct packed {
      logic [10:0] op;
      logic        z;
      logic        has_m;
      logic        has_w;
      logic [12:0] d;
      logic [12:0] e;
      logic [12:0] m;
      logic [12:0] w;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;
   int   exp_ret = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] s, input logic [12:0] o, input int rep);
      for (int i = 0; i < rep; i++) sb.push_back('{st: s, out: o});
   endtask

   // Drive one opcode and per-cycle mem_ready, comparing each cycle against
   // the queued expectations. Called right after a falling edge.
   task automatic run(input logic [10:0] op, input logic z, input int n, input logic [63:0] rdy);
      exp_t e;
      inst31_21 = op;
      zero      = z;
      for (int k = 0; k < n; k++) begin
         mem_ready = rdy[k];
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("state", {13'd0, state}, {13'd0, e.st});
            chk("outputs", {3'd0, out_w}, {3'd0, e.out});
         end
         @(negedge clk);
      end
   endtask

   task automatic chk_ret(input string nm);
      chk(nm, {{(16-RW_W){1'b0}}, retire_cnt}, 16'(exp_ret));
   endtask

   // Reset with checks on the reset values; leaves DUT in FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state", {13'd0, state}, 16'd0);
      chk("rst_outputs", {3'd0, out_w}, 16'd0);
      exp_ret = 0;
      chk_ret("rst_retire");
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{11'b10001011000, 1'b0, 1'b0, 1'b1, O_NONE, AOP10, O_NONE, RW};        // ADD
      vecs[1] = '{11'b11001011000, 1'b1, 1'b0, 1'b1, O_NONE, AOP10, O_NONE, RW};        // SUB
      vecs[2] = '{11'b10001010000, 1'b0, 1'b0, 1'b1, O_NONE, AOP10, O_NONE, RW};        // AND
      vecs[3] = '{11'b10101010000, 1'b0, 1'b0, 1'b1, O_NONE, AOP10, O_NONE, RW};        // ORR
      vecs[4] = '{11'b11111000010, 1'b0, 1'b1, 1'b1, O_NONE, AS, MR | AS, RW | M2R};    // LDUR
      vecs[5] = '{11'b11111000000, 1'b0, 1'b1, 1'b0, R2L, AS, MW | R2L | AS, O_NONE};   // STUR
      vecs[6] = '{11'b10110100101, 1'b1, 1'b0, 1'b0, R2L, R2L | AOP01 | BR | PCW, O_NONE, O_NONE}; // CBZ taken
      vecs[7] = '{11'b10110100010, 1'b0, 1'b0, 1'b0, R2L, R2L | AOP01 | BR, O_NONE, O_NONE};       // CBZ not taken
      vecs[8] = '{11'b00010100000, 1'b0, 1'b0, 1'b0, O_NONE, BR | PCW, O_NONE, O_NONE}; // B

      rst_n = 1'b0; mem_ready = 1'b0; inst31_21 = 11'd0; zero = 1'b0;
      @(negedge clk);
      chk("rst_state", {13'd0, state}, 16'd0);
      chk("rst_outputs", {3'd0, out_w}, 16'd0);
      chk_ret("rst_retire");
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      chk("idle_after_release", {13'd0, state}, 16'd0);
      @(negedge clk);

      // Table: each instruction with mem_ready tied high.
      for (int v = 0; v < 9; v++) begin
         push(3'd1, F_DONE, 1);
         push(3'd2, vecs[v].d, 1);
         push(3'd3, vecs[v].e, 1);
         if (vecs[v].has_m) push(3'd4, vecs[v].m, 1);
         if (vecs[v].has_w) push(3'd5, vecs[v].w, 1);
         run(vecs[v].op, vecs[v].z, 3 + int'(vecs[v].has_m) + int'(vecs[v].has_w), 64'hFFFF_FFFF_FFFF_FFFF);
         exp_ret = (exp_ret < 7) ? exp_ret + 1 : 7;
         chk_ret("retire_vec");
      end
      #1;
      chk("back_in_fetch", {13'd0, state}, 16'd1);
      do_reset();

      // LDUR with three stalled MEM cycles.
      push(3'd1, F_DONE, 1);
      push(3'd2, O_NONE, 1);
      push(3'd3, AS, 1);
      push(3'd4, MR | AS, 4);
      push(3'd5, RW | M2R, 1);
      run(11'b11111000010, 1'b0, 8, 64'h0000_0000_0000_00C7);
      exp_ret = 1;
      chk_ret("retire_ldur_stall");

      // HALT: sticky, no further fetch.
      push(3'd1, F_DONE, 1);
      push(3'd2, O_NONE, 1);
      push(3'd6, O_HLT, 20);
      run(11'b11111111111, 1'b0, 22, 64'hFFFF_FFFF_FFFF_FFFF);
      exp_ret = 2;
      chk_ret("retire_halt");
      do_reset();

      // Illegal opcode.
      push(3'd1, F_DONE, 1);
      push(3'd2, O_NONE, 1);
      push(3'd7, O_ERR, 5);
      run(11'b00000000000, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FFFF);
      chk_ret("retire_illegal");
      do_reset();

      // 15 stalled FETCH cycles, ready arrives as the counter hits the limit.
      push(3'd1, MR, 15);
      push(3'd1, F_DONE, 1);
      push(3'd2, O_NONE, 1);
      push(3'd3, AOP10, 1);
      push(3'd5, RW, 1);
      run(11'b10001011000, 1'b0, 19, 64'hFFFF_FFFF_FFFF_8000);
      exp_ret = 1;
      chk_ret("retire_boundary");

      // 16 stalled FETCH cycles -> timeout error.
      push(3'd1, MR, 16);
      push(3'd7, O_ERR, 4);
      run(11'b10001011000, 1'b0, 20, 64'h0);
      do_reset();

      // Reset asserted mid-MEM of a STUR.
      push(3'd1, F_DONE, 1);
      push(3'd2, R2L, 1);
      push(3'd3, AS, 1);
      run(11'b11111000000, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
      mem_ready = 1'b0;
      #1;
      chk("stur_mem_state", {13'd0, state}, 16'd4);
      chk("stur_mem_out", {3'd0, out_w}, {3'd0, MW | R2L | AS});
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_state", {13'd0, state}, 16'd0);
      chk("abort_outputs", {3'd0, out_w}, 16'd0);
      exp_ret = 0;
      chk_ret("abort_retire");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_idle", {13'd0, state}, 16'd0);
      @(negedge clk);
      #1;
      chk("abort_fetch_state", {13'd0, state}, 16'd1);
      chk("abort_fetch_out", {3'd0, out_w}, {3'd0, MR});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
